// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART transmit arbiter
package uart_pkg;

    localparam int NUM_REQ_DEF      = 4;
    localparam int LOCK_TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_SEND,
        ST_WAIT_DONE,
        ST_HOLD
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or after ptr
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  winner
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter feeding one UART transmitter
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = NUM_REQ_DEF,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 uart_send,
    output logic [7:0]           uart_data,
    input  logic                 uart_tx_done,
    output logic                 busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [7:0]         uart_data_q, uart_data_d;
    logic               uart_send_q, uart_send_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic [TW-1:0]      timer_q, timer_d;

    logic [NUM_REQ-1:0] winner;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      sel_idx;
    logic [IW-1:0]      next_ptr;
    logic [7:0]         req_bytes [NUM_REQ];
    logic               take;
    logic               drop;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req    (req_valid),
        .ptr    (ptr_q),
        .winner (winner)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[i*8 +: 8];
            if (winner[i]) begin
                win_idx = IW'(i);
            end
        end
    end

    // After a release the requester following the owner gets first look.
    assign next_ptr = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        req_ready_d = '0;
        uart_send_d = 1'b0;
        uart_data_d = uart_data_q;
        last_d      = last_q;
        timer_d     = timer_q;
        sel_idx     = owner_q;
        take        = 1'b0;
        drop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((|req_valid) && uart_tx_done) begin
                    grant_d = winner;
                    owner_d = win_idx;
                    sel_idx = win_idx;
                    take    = 1'b1;
                end
            end
            ST_ACCEPT: begin
                state_d     = ST_SEND;
                uart_send_d = 1'b1;
            end
            ST_SEND: begin
                if (!uart_tx_done) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    uart_send_d = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (uart_tx_done) begin
                    if (last_q) begin
                        drop = 1'b1;
                    end else if (req_valid[owner_q]) begin
                        take = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        timer_d = '0;
                    end
                end
            end
            ST_HOLD: begin
                if (req_valid[owner_q]) begin
                    take = 1'b1;
                end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                    drop = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // The byte is captured on the way into ACCEPT so it is already on
        // uart_data while req_ready pulses.
        if (take) begin
            state_d              = ST_ACCEPT;
            req_ready_d[sel_idx] = 1'b1;
            uart_data_d          = req_bytes[sel_idx];
            last_d               = req_last[sel_idx];
        end
        if (drop) begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = next_ptr;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            ptr_q       <= '0;
            req_ready_q <= '0;
            uart_send_q <= 1'b0;
            uart_data_q <= 8'h00;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            req_ready_q <= req_ready_d;
            uart_send_q <= uart_send_d;
            uart_data_q <= uart_data_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            timer_q     <= timer_d;
        end
    end

    assign req_ready = req_ready_q;
    assign grant     = grant_q;
    assign uart_send = uart_send_q;
    assign uart_data = uart_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a 2-cycle transmitter model
module tb_uart_tx_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data  = '0;
    logic [N-1:0]   req_last  = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           uart_send;
    logic [7:0]     uart_data;
    logic           uart_tx_done = 1'b1;
    logic           busy;

    int   vectors     = 0;
    int   miscompares = 0;
    int   ready_cnt   = 0;
    int   send_cnt    = 0;
    int   tx_cnt      = 0;
    logic prev_send   = 1'b0;
    exp_t expq[$];
    logic [8:0] pmem [N][16];
    int   wp [N];
    int   rp [N];

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .LOCK_TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .grant        (grant),
        .uart_send    (uart_send),
        .uart_data    (uart_data),
        .uart_tx_done (uart_tx_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input logic [1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic bit fifos_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (rp[i] != wp[i]) e = 1'b0;
        end
        return e;
    endfunction

    task automatic push(input int i, input logic [7:0] d, input logic l);
        pmem[i][wp[i] % 16] = {l, d};
        wp[i]++;
    endtask

    task automatic expect_byte(input logic [1:0] i, input logic [7:0] d);
        exp_t e;
        e.idx  = i;
        e.data = d;
        expq.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_uart_send"}, uart_send, 0);
        chk({tag, "_uart_data"}, uart_data, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic wait_drain(input int limit, input logic [N-1:0] hold, input string tag);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < limit) begin
            @(negedge clk);
            n++;
            if (hold != 0 && busy) chk({tag, "_grant_held"}, grant, hold);
            if (fifos_empty() && expq.size() == 0 && !busy) ok = 1'b1;
        end
        chk({tag, "_drain_timeout"}, ok, 1);
    endtask

    task automatic wait_ready(input int i, input int limit, input string tag);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < limit) begin
            @(negedge clk);
            n++;
            if (req_ready[i]) ok = 1'b1;
        end
        chk({tag, "_ready_timeout"}, ok, 1);
    endtask

    // Requesters: present the head byte, advance on req_ready, abandon on reset.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) rp[i] = wp[i];
            else if (req_ready[i] && rp[i] != wp[i]) rp[i]++;
            if (rp[i] != wp[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = pmem[i][rp[i] % 16][7:0];
                req_last[i]        = pmem[i][rp[i] % 16][8];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    end

    // Transmitter: goes busy for two cycles once it sees the send strobe.
    always @(negedge clk) begin
        if (rst) begin
            uart_tx_done = 1'b1;
            tx_cnt       = 0;
        end else if (uart_send && uart_tx_done && tx_cnt == 0) begin
            uart_tx_done = 1'b0;
            tx_cnt       = 2;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) uart_tx_done = 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_send = 1'b0;
        end else begin
            if (req_ready != 0) begin
                ready_cnt++;
                chk("ready_is_owner", req_ready, grant);
            end
            if (uart_send && !prev_send) begin
                send_cnt++;
                if (expq.size() == 0) begin
                    chk("send_without_expectation", expq.size(), 1);
                end else begin
                    e = expq.pop_front();
                    chk("uart_data", uart_data, e.data);
                    chk("send_grant", grant, onehot(e.idx));
                end
            end
            prev_send = uart_send;
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;

        push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
        expect_byte(0, 8'h41); expect_byte(0, 8'h42); expect_byte(0, 8'h43);
        wait_drain(200, 4'b0001, "t1");
        chk("t1_busy_after", busy, 0);
        chk("t1_ready_pulses", ready_cnt, 3);

        rst = 1'b1;
        @(negedge clk);
        check_reset("t2_rst");
        rst = 1'b0;
        push(1, 8'hA1, 1'b1); push(1, 8'hA2, 1'b1);
        push(2, 8'hB1, 1'b1); push(2, 8'hB2, 1'b1);
        expect_byte(1, 8'hA1); expect_byte(2, 8'hB1);
        expect_byte(1, 8'hA2); expect_byte(2, 8'hB2);
        wait_drain(300, '0, "t2");

        push(0, 8'h30, 1'b0);
        expect_byte(0, 8'h30);
        wait_ready(0, 50, "t3");
        push(3, 8'h33, 1'b1);
        expect_byte(0, 8'h55); expect_byte(3, 8'h33);
        repeat (10) @(negedge clk);
        chk("t3_lock_held", grant, 4'b0001);
        push(0, 8'h55, 1'b1);
        wait_drain(300, '0, "t3");

        push(1, 8'h60, 1'b0);
        expect_byte(1, 8'h60); expect_byte(2, 8'h62);
        wait_ready(1, 50, "t4");
        push(2, 8'h62, 1'b1);
        repeat (19) @(negedge clk);
        chk("t4_hold_last_cycle", grant, 4'b0010);
        @(negedge clk);
        chk("t4_released_grant", grant, 0);
        chk("t4_released_busy", busy, 0);
        @(negedge clk);
        chk("t4_next_grant", grant, 4'b0100);
        wait_drain(300, '0, "t4");

        push(2, 8'h70, 1'b0); push(2, 8'h71, 1'b1);
        expect_byte(2, 8'h70);
        begin
            int n;
            n = 0;
            while (!uart_send && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("t5_send_seen", uart_send, 1);
        end
        #1 rst = 1'b1;
        #1 check_reset("t5_async");
        @(negedge clk);
        check_reset("t5_next");
        @(negedge clk);
        rst = 1'b0;
        push(2, 8'h72, 1'b1);
        expect_byte(2, 8'h72);
        wait_drain(200, 4'b0100, "t5");

        chk("ready_vs_send", ready_cnt, send_cnt);
        chk("scoreboard_empty", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
